// File: rtl/alu_pkg.sv
// Shared types for the ALU issue unit: ALU control codes, GES encodings,
// micro-op classes and the attribute bundle carried alongside the operands.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SRL  = 4'b0010,
    ALU_SRA  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_UCMP = 4'b1000,
    ALU_SCMP = 4'b1001
  } alu_op_e;

  localparam logic [2:0] GES_GT = 3'b100;
  localparam logic [2:0] GES_EQ = 3'b010;
  localparam logic [2:0] GES_LT = 3'b001;

  typedef enum logic [1:0] {
    CLS_R   = 2'd0,
    CLS_I   = 2'd1,
    CLS_BR  = 2'd2,
    CLS_RSV = 2'd3
  } op_class_e;

  // Decoder verdict. A compare result is (GES == LT) when cmp_lt, else
  // (GES == EQ), optionally inverted; slt/sltu and all branches use it.
  typedef struct packed {
    alu_op_e op;
    logic    use_imm;
    logic    is_br;
    logic    is_cmp;
    logic    cmp_lt;
    logic    cmp_inv;
    logic    illegal;
  } dec_t;

  // Everything S2 needs besides the ALU outputs.
  typedef struct packed {
    logic [4:0] rd;
    logic       is_br;
    logic       is_cmp;
    logic       cmp_lt;
    logic       cmp_inv;
    logic       illegal;
  } s1_attr_t;

endpackage

// File: rtl/ALU.sv
// Combinational integer ALU: arithmetic/logic result plus a one-hot
// greater/equal/less flag for the two compare codes.
module ALU (
  input  logic [31:0] Arg1,
  input  logic [31:0] Arg2,
  input  logic [3:0]  ALU_Control,
  output logic [31:0] ALUResult,
  output logic [2:0]  GES
);

  // Arithmetic and logic result.
  always_comb begin
    ALUResult = 32'd0;
    case (ALU_Control)
      4'b0000: ALUResult = Arg1 + Arg2;
      4'b0001: ALUResult = Arg1 - Arg2;
      4'b0010: ALUResult = Arg1 >> Arg2[4:0];
      4'b0011: ALUResult = $signed(Arg1) >>> Arg2[4:0];
      4'b0100: ALUResult = Arg1 << Arg2[4:0];
      4'b0101: ALUResult = Arg1 ^ Arg2;
      4'b0110: ALUResult = Arg1 | Arg2;
      4'b0111: ALUResult = Arg1 & Arg2;
      default: ALUResult = 32'd0;
    endcase
  end

  // Compare flags, only meaningful for the unsigned/signed compare codes.
  always_comb begin
    GES = 3'b000;
    if (ALU_Control == 4'b1000) begin
      if (Arg1 > Arg2)       GES = 3'b100;
      else if (Arg1 == Arg2) GES = 3'b010;
      else                   GES = 3'b001;
    end else if (ALU_Control == 4'b1001) begin
      if ($signed(Arg1) > $signed(Arg2)) GES = 3'b100;
      else if (Arg1 == Arg2)             GES = 3'b010;
      else                               GES = 3'b001;
    end
  end

endmodule

// File: rtl/alu_op_decode.sv
// Translates micro-op class/funct3/f7b5 into an ALU code, operand select,
// compare interpretation and an illegal flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  op_class_e  op_class,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output dec_t       dec
);

  // Decode table; illegal encodings keep ALU_ADD so the ALU never sees 1010-1111.
  always_comb begin
    dec         = '0;
    dec.op      = ALU_ADD;
    case (op_class)
      CLS_R, CLS_I: begin
        dec.use_imm = (op_class == CLS_I);
        case (funct3)
          3'b000: if (op_class == CLS_R && f7b5) dec.op = ALU_SUB;
          3'b001: begin
            dec.op      = ALU_SLL;
            dec.illegal = f7b5;
          end
          3'b010: begin
            dec.op      = ALU_SCMP;
            dec.is_cmp  = 1'b1;
            dec.cmp_lt  = 1'b1;
            dec.illegal = (op_class == CLS_R) && f7b5;
          end
          3'b011: begin
            dec.op      = ALU_UCMP;
            dec.is_cmp  = 1'b1;
            dec.cmp_lt  = 1'b1;
            dec.illegal = (op_class == CLS_R) && f7b5;
          end
          3'b100: begin
            dec.op      = ALU_XOR;
            dec.illegal = (op_class == CLS_R) && f7b5;
          end
          3'b101: dec.op = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110: begin
            dec.op      = ALU_OR;
            dec.illegal = (op_class == CLS_R) && f7b5;
          end
          default: begin
            dec.op      = ALU_AND;
            dec.illegal = (op_class == CLS_R) && f7b5;
          end
        endcase
      end
      CLS_BR: begin
        dec.is_br  = 1'b1;
        dec.is_cmp = 1'b1;
        case (funct3)
          3'b000: dec.op = ALU_UCMP;
          3'b001: begin
            dec.op      = ALU_UCMP;
            dec.cmp_inv = 1'b1;
          end
          3'b100: begin
            dec.op     = ALU_SCMP;
            dec.cmp_lt = 1'b1;
          end
          3'b101: begin
            dec.op      = ALU_SCMP;
            dec.cmp_lt  = 1'b1;
            dec.cmp_inv = 1'b1;
          end
          3'b110: begin
            dec.op     = ALU_UCMP;
            dec.cmp_lt = 1'b1;
          end
          3'b111: begin
            dec.op      = ALU_UCMP;
            dec.cmp_lt  = 1'b1;
            dec.cmp_inv = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage issue front-end around the combinational ALU. S1 holds the
// decoded operands/attributes and drives the ALU; S2 is the result register.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [2:0]       in_funct3,
  input  logic             in_f7b5,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [4:0]       in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [4:0]       out_rd,
  output logic             out_wen,
  output logic             out_br,
  output logic             out_taken,
  output logic             out_illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  dec_t            dec;
  logic            s1_valid;
  logic [XLEN-1:0] s1_arg1;
  logic [XLEN-1:0] s1_arg2;
  alu_op_e         s1_op;
  s1_attr_t        s1_attr;
  logic [XLEN-1:0] alu_result;
  logic [2:0]      alu_ges;
  logic            s1_load;
  logic            s2_load;
  logic            cond;
  logic [XLEN-1:0] res_data;
  logic            res_wen;
  logic            res_taken;

  alu_op_decode u_decode (
    .op_class (op_class_e'(in_class)),
    .funct3   (in_funct3),
    .f7b5     (in_f7b5),
    .dec      (dec)
  );

  // Handshake: S1 may refill in the same cycle S2 drains it.
  always_comb begin
    s2_load  = s1_valid && (!out_valid || out_ready);
    in_ready = !s1_valid || s2_load;
    s1_load  = in_valid && in_ready;
  end

  // S1: decoded operands and attributes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_arg1  <= '0;
      s1_arg2  <= '0;
      s1_op    <= ALU_ADD;
      s1_attr  <= '0;
    end else begin
      if (s1_load) begin
        s1_valid        <= 1'b1;
        s1_arg1         <= in_rs1;
        s1_arg2         <= dec.use_imm ? in_imm : in_rs2;
        s1_op           <= dec.op;
        s1_attr.rd      <= in_rd;
        s1_attr.is_br   <= dec.is_br;
        s1_attr.is_cmp  <= dec.is_cmp;
        s1_attr.cmp_lt  <= dec.cmp_lt;
        s1_attr.cmp_inv <= dec.cmp_inv;
        s1_attr.illegal <= dec.illegal;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  ALU u_alu (
    .Arg1        (s1_arg1),
    .Arg2        (s1_arg2),
    .ALU_Control (s1_op),
    .ALUResult   (alu_result),
    .GES         (alu_ges)
  );

  // Result shaping: compares derive purely from GES, illegal ops zero out.
  always_comb begin
    cond      = (s1_attr.cmp_lt ? (alu_ges == GES_LT) : (alu_ges == GES_EQ))
                ^ s1_attr.cmp_inv;
    res_data  = alu_result;
    if (s1_attr.is_cmp)
      res_data = {{(XLEN-1){1'b0}}, cond};
    if (s1_attr.is_br || s1_attr.illegal)
      res_data = '0;
    res_wen   = !s1_attr.is_br && !s1_attr.illegal && (s1_attr.rd != 5'd0);
    res_taken = s1_attr.is_br && !s1_attr.illegal && cond;
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_rd      <= '0;
      out_wen     <= 1'b0;
      out_br      <= 1'b0;
      out_taken   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (s2_load) begin
      out_valid   <= 1'b1;
      out_data    <= res_data;
      out_rd      <= s1_attr.rd;
      out_wen     <= res_wen;
      out_br      <= s1_attr.is_br;
      out_taken   <= res_taken;
      out_illegal <= s1_attr.illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Retire counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retire_cnt <= '0;
    else if (out_valid && out_ready)
      retire_cnt <= retire_cnt + 1'b1;
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: a reference model predicts each
// accepted micro-op, results are popped and compared at the output handshake.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [31:0] in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen, out_br, out_taken, out_illegal;
  logic [15:0] retire_cnt;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wen;
    logic        br;
    logic        taken;
    logic        ill;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;
  int          n_sent = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_class    (in_class),
    .in_funct3   (in_funct3),
    .in_f7b5     (in_f7b5),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_rd      (out_rd),
    .out_wen     (out_wen),
    .out_br      (out_br),
    .out_taken   (out_taken),
    .out_illegal (out_illegal),
    .retire_cnt  (retire_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // RV32I reference semantics.
  function automatic exp_t model(input logic [1:0] cls, input logic [2:0] f3,
                                 input logic f7, input logic [31:0] a,
                                 input logic [31:0] rs2, input logic [31:0] imm,
                                 input logic [4:0] rd);
    exp_t        e;
    logic [31:0] b;
    logic        r;
    logic        c;
    e    = '0;
    e.rd = rd;
    c    = 1'b0;
    r    = (cls == 2'd0);
    b    = (cls == 2'd1) ? imm : rs2;
    if (cls <= 2'd1) begin
      case (f3)
        3'd0: e.data = (r && f7) ? a - b : a + b;
        3'd1: begin e.data = a << b[4:0]; e.ill = f7; end
        3'd2: begin e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; e.ill = r && f7; end
        3'd3: begin e.data = (a < b) ? 32'd1 : 32'd0; e.ill = r && f7; end
        3'd4: begin e.data = a ^ b; e.ill = r && f7; end
        3'd5: begin
          if (f7) e.data = $signed(a) >>> b[4:0];
          else    e.data = a >> b[4:0];
        end
        3'd6: begin e.data = a | b; e.ill = r && f7; end
        default: begin e.data = a & b; e.ill = r && f7; end
      endcase
    end else if (cls == 2'd2) begin
      e.br = 1'b1;
      case (f3)
        3'd0: c = (a == b);
        3'd1: c = (a != b);
        3'd4: c = ($signed(a) < $signed(b));
        3'd5: c = ($signed(a) >= $signed(b));
        3'd6: c = (a < b);
        3'd7: c = (a >= b);
        default: e.ill = 1'b1;
      endcase
      e.taken = c && !e.ill;
      e.data  = '0;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e.data = '0;
    e.wen = !e.ill && !e.br && (rd != 5'd0);
    return e;
  endfunction

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb_q.delete();
      exp_cnt = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data",    out_data,    e.data);
          chk("sb_rd",      32'(out_rd), 32'(e.rd));
          chk("sb_wen",     32'(out_wen), 32'(e.wen));
          chk("sb_br",      32'(out_br), 32'(e.br));
          chk("sb_taken",   32'(out_taken), 32'(e.taken));
          chk("sb_illegal", 32'(out_illegal), 32'(e.ill));
          chk("sb_retire",  32'(retire_cnt), 32'(exp_cnt));
          exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(in_class, in_funct3, in_f7b5, in_rs1, in_rs2, in_imm, in_rd));
    end
  end

  task automatic set_op(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [4:0] rd);
    in_class  = cls;
    in_funct3 = f3;
    in_f7b5   = f7;
    in_rs1    = a;
    in_rs2    = b;
    in_imm    = imm;
    in_rd     = rd;
  endtask

  // Present the current op until accepted; called just after a rising edge.
  task automatic send();
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (acc) n_sent++;
    else     chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = (sb_q.size() == 0) && !out_valid;
    end
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // One directed op with literal expectations and latency check.
  task automatic run1(input string tag, input logic [1:0] cls, input logic [2:0] f3,
                      input logic f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [4:0] rd,
                      input logic [31:0] x_data, input logic x_wen,
                      input logic x_taken, input logic x_ill);
    int n;
    set_op(cls, f3, f7, a, b, imm, rd);
    send();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    if (!out_valid) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_lat"},   32'(n), 32'd2);
      chk({tag, "_data"},  out_data, x_data);
      chk({tag, "_wen"},   32'(out_wen), 32'(x_wen));
      chk({tag, "_taken"}, 32'(out_taken), 32'(x_taken));
      chk({tag, "_ill"},   32'(out_illegal), 32'(x_ill));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit          have, acc, did_rst;
    int          done, cyc, r;
    logic [1:0]  cls;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(2'd0, 3'd0, 1'b0, 32'd1, 32'd2, 32'd0, 5'd1);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_retire",    32'(retire_cnt), 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rel_in_ready",  32'(in_ready), 32'd1);
    chk("rel_out_valid", 32'(out_valid), 32'd0);
    chk("rel_retire",    32'(retire_cnt), 32'd0);
    @(posedge clk);
    #1;

    run1("add",   2'd0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3, 32'd12, 1'b1, 1'b0, 1'b0);
    run1("sub",   2'd0, 3'd0, 1'b1, 32'd0, 32'd1, 32'd0, 5'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run1("srai",  2'd1, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 5'd5, 32'hF800_0000, 1'b1, 1'b0, 1'b0);
    run1("srli",  2'd1, 3'd5, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 5'd5, 32'h0800_0000, 1'b1, 1'b0, 1'b0);
    run1("slt",   2'd0, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 32'd1, 1'b1, 1'b0, 1'b0);
    run1("sltu",  2'd0, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 32'd0, 1'b1, 1'b0, 1'b0);
    run1("bge",   2'd2, 3'd5, 1'b0, 32'd3, 32'd3, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    run1("bltu",  2'd2, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    run1("br010", 2'd2, 3'd2, 1'b0, 32'd3, 32'd3, 32'd0, 5'd7, 32'd0, 1'b0, 1'b0, 1'b1);
    run1("cls3",  2'd3, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 5'd7, 32'd0, 1'b0, 1'b0, 1'b1);
    run1("rd0",   2'd0, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd0, 32'd12, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("retire_directed", 32'(retire_cnt), 32'(n_sent));
    @(posedge clk);
    #1;

    // Back-pressure: two ops fill the pipe, the third must wait.
    out_ready = 1'b0;
    set_op(2'd0, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
    send();
    set_op(2'd0, 3'd0, 1'b0, 32'd2, 32'd2, 32'd0, 5'd2);
    send();
    set_op(2'd0, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 5'd3);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data",  out_data, 32'd2);
      chk("stall_out_rd",    32'(out_rd), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send();
    drain();
    @(negedge clk);
    chk("retire_after_stall", 32'(retire_cnt), 32'(n_sent));
    @(posedge clk);
    #1;

    // Random stream with mid-stream reset.
    have    = 1'b0;
    done    = 0;
    did_rst = 1'b0;
    for (cyc = 0; cyc < 40000 && done < 10000; cyc++) begin
      if (done == 5000 && !did_rst) begin
        did_rst  = 1'b1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        have     = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_retire",    32'(retire_cnt), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
      end
      if (!have) begin
        r   = $urandom_range(0, 15);
        cls = (r < 6) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
        in_class  = cls;
        in_funct3 = 3'($urandom_range(0, 7));
        in_f7b5   = 1'($urandom_range(0, 1));
        in_rs1    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
        in_rs2    = ($urandom_range(0, 3) == 0) ? in_rs1 : $urandom;
        in_imm    = $urandom;
        in_rd     = 5'($urandom_range(0, 31));
        have      = 1'b1;
      end
      in_valid  = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 4) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        have = 1'b0;
        done++;
      end
    end
    if (done < 10000) chk("random_timeout", 32'(done), 32'd10000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
